// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: single-port main memory arbiter, data-priority with bounded fetch starvation
module main_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_gnt,
  output logic              data_rvalid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        streak_count
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] streak;
  logic resp_valid, resp_owner;
  always_comb begin
    data_gnt = data_req && !(fetch_req && streak == LIMIT);
    fetch_gnt = fetch_req && !data_gnt;
    mem_en = fetch_gnt | data_gnt;
    mem_we = data_gnt & data_we;
    mem_addr = data_gnt ? data_addr : fetch_gnt ? fetch_addr : '0;
    mem_wdata = data_gnt ? data_wdata : '0;
    fetch_rvalid = resp_valid & !resp_owner;
    data_rvalid = resp_valid & resp_owner;
    fetch_rdata = fetch_rvalid ? mem_rdata : '0;
    data_rdata = data_rvalid ? mem_rdata : '0;
    streak_count = streak;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      streak <= '0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
    end else begin
      streak <= (fetch_gnt || !fetch_req) ? 4'd0 :
                (data_gnt && streak != LIMIT) ? streak + 4'd1 : streak;
      resp_valid <= fetch_gnt | (data_gnt & !data_we);
      resp_owner <= data_gnt;
    end
endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed checks of arbitration, starvation bound, routing and reset
module tb_main_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic fetch_gnt, fetch_rvalid, data_gnt, data_rvalid, mem_en, mem_we;
  logic [31:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;
  logic [3:0] streak_count;
  int n_cmp = 0, n_err = 0;

  main_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .streak_count(streak_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_rdata = 32'hFFFF_FFFF;
    #2;
    chk("rst_frv", fetch_rvalid, 0);
    chk("rst_drv", data_rvalid, 0);
    chk("rst_frd", fetch_rdata, 0);
    chk("rst_drd", data_rdata, 0);
    chk("rst_streak", streak_count, 0);
    @(negedge clk);
    rst = 1'b1;
    // fetch only
    cyc();
    fetch_req = 1; fetch_addr = 32'h10; mem_rdata = 0;
    #1;
    chk("f_gnt", fetch_gnt, 1);
    chk("f_dgnt", data_gnt, 0);
    chk("f_en", mem_en, 1);
    chk("f_addr", mem_addr, 32'h10);
    chk("f_we", mem_we, 0);
    chk("f_wdata", mem_wdata, 0);
    cyc();
    fetch_req = 0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("f_rv", fetch_rvalid, 1);
    chk("f_rd", fetch_rdata, 32'hDEAD_BEEF);
    chk("f_drv", data_rvalid, 0);
    chk("f_drd", data_rdata, 0);
    chk("f_idle_en", mem_en, 0);
    chk("f_idle_addr", mem_addr, 0);
    // collision
    cyc();
    fetch_req = 1; fetch_addr = 32'h14; data_req = 1; data_we = 0; data_addr = 32'h20; mem_rdata = 0;
    #1;
    chk("c_dgnt", data_gnt, 1);
    chk("c_fgnt", fetch_gnt, 0);
    chk("c_addr", mem_addr, 32'h20);
    chk("c_streak0", streak_count, 0);
    cyc();
    data_req = 0; mem_rdata = 32'hAAAA_0001;
    #1;
    chk("c_fgnt2", fetch_gnt, 1);
    chk("c_addr2", mem_addr, 32'h14);
    chk("c_drv", data_rvalid, 1);
    chk("c_drd", data_rdata, 32'hAAAA_0001);
    chk("c_frd0", fetch_rdata, 0);
    chk("c_streak1", streak_count, 1);
    cyc();
    fetch_req = 0; mem_rdata = 32'hBBBB_0002;
    #1;
    chk("c_frv", fetch_rvalid, 1);
    chk("c_frd", fetch_rdata, 32'hBBBB_0002);
    chk("c_drv0", data_rvalid, 0);
    chk("c_streak_clr", streak_count, 0);
    // starvation bound
    cyc();
    fetch_req = 1; fetch_addr = 32'h18; data_req = 1; data_addr = 32'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("s_dgnt%0d", i), data_gnt, 1);
      chk($sformatf("s_streak%0d", i), streak_count, i);
      cyc();
    end
    #1;
    chk("s_fgnt", fetch_gnt, 1);
    chk("s_dgnt_blk", data_gnt, 0);
    chk("s_streak4", streak_count, 4);
    chk("s_addr", mem_addr, 32'h18);
    cyc();
    mem_rdata = 32'hCAFE_0005;
    #1;
    chk("s_resume", data_gnt, 1);
    chk("s_streak_clr", streak_count, 0);
    chk("s_frv", fetch_rvalid, 1);
    chk("s_frd", fetch_rdata, 32'hCAFE_0005);
    cyc();
    fetch_req = 0; data_req = 0;
    // store
    cyc();
    data_req = 1; data_we = 1; data_addr = 32'h40; data_wdata = 32'h1234;
    #1;
    chk("w_gnt", data_gnt, 1);
    chk("w_en", mem_en, 1);
    chk("w_we", mem_we, 1);
    chk("w_addr", mem_addr, 32'h40);
    chk("w_wdata", mem_wdata, 32'h1234);
    cyc();
    data_req = 0; data_we = 0; mem_rdata = 32'h5555;
    #1;
    chk("w_drv", data_rvalid, 0);
    chk("w_frv", fetch_rvalid, 0);
    chk("w_drd", data_rdata, 0);
    chk("w_streak", streak_count, 0);
    chk("w_we0", mem_we, 0);
    // back-to-back mix
    cyc();
    fetch_req = 1; fetch_addr = 32'h50;
    #1;
    chk("b_fgnt0", fetch_gnt, 1);
    cyc();
    fetch_req = 0; data_req = 1; data_addr = 32'h60; mem_rdata = 32'h1111_1111;
    #1;
    chk("b_dgnt1", data_gnt, 1);
    chk("b_frv1", fetch_rvalid, 1);
    chk("b_frd1", fetch_rdata, 32'h1111_1111);
    chk("b_drd1", data_rdata, 0);
    cyc();
    data_req = 0; fetch_req = 1; fetch_addr = 32'h54; mem_rdata = 32'h2222_2222;
    #1;
    chk("b_fgnt2", fetch_gnt, 1);
    chk("b_drv2", data_rvalid, 1);
    chk("b_drd2", data_rdata, 32'h2222_2222);
    chk("b_frd2", fetch_rdata, 0);
    cyc();
    fetch_req = 0; mem_rdata = 32'h3333_3333;
    #1;
    chk("b_frv3", fetch_rvalid, 1);
    chk("b_frd3", fetch_rdata, 32'h3333_3333);
    chk("b_drv3", data_rvalid, 0);
    // reset mid-read
    cyc();
    fetch_req = 1; fetch_addr = 32'h70;
    #1;
    chk("r_fgnt", fetch_gnt, 1);
    #1;
    rst = 0;
    #1;
    chk("r_frv_async", fetch_rvalid, 0);
    cyc();
    fetch_req = 0; mem_rdata = 32'h77;
    #1;
    chk("r_frv", fetch_rvalid, 0);
    chk("r_frd", fetch_rdata, 0);
    rst = 1;
    cyc();
    mem_rdata = 32'h88;
    #1;
    chk("r_frv_post", fetch_rvalid, 0);
    fetch_req = 1; data_req = 1; data_we = 0; data_addr = 32'h80;
    #1;
    chk("r_streak", streak_count, 0);
    chk("r_dgnt", data_gnt, 1);
    chk("r_fgnt0", fetch_gnt, 0);
    cyc();
    fetch_req = 0; data_req = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
